// File: rtl/counter_share_arbiter.sv
// Time-shares one up-counter among NREQ requesters: round-robin grant, count to
// the granted duration, pulse done to the winner, then re-arbitrate.
module counter_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    dur,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy,
  output logic [NREQ-1:0]          done,
  output logic [WIDTH-1:0]         count
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [IDW-1:0]   ptr_reg;
  logic [WIDTH-1:0] dur_q_reg;

  logic             any_req;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   ptr_next;
  logic [NREQ-1:0]  winner_onehot;

  // Scan downward through the rotated order so the last hit is the first
  // requester at or after the pointer.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr_reg) + k) % NREQ;
      if (req[idx]) begin
        any_req = 1'b1;
        winner  = IDW'(idx);
      end
    end
  end

  assign ptr_next      = (int'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);
  assign winner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << winner;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      dur_q_reg <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      busy      <= 1'b0;
      done      <= '0;
      count     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= '0;
          if (any_req) begin
            gnt       <= winner_onehot;
            gnt_id    <= winner;
            dur_q_reg <= dur[int'(winner)*WIDTH +: WIDTH];
            ptr_reg   <= ptr_next;
            count     <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          // A dropped request aborts silently and wins over completion.
          if (!req[gnt_id]) begin
            gnt       <= '0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else if (count == dur_q_reg) begin
            done      <= gnt;
            gnt       <= '0;
            busy      <= 1'b0;
            state_reg <= DONE;
          end else begin
            count <= count + WIDTH'(1);
          end
        end
        DONE: begin
          done      <= '0;
          state_reg <= IDLE;
        end
        default: begin
          gnt       <= '0;
          busy      <= 1'b0;
          done      <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Directed self-checking bench for counter_share_arbiter (NREQ=4, WIDTH=16).
module tb_counter_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clock;
  logic              resetN;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] dur;
  logic [NREQ-1:0]   gnt;
  logic [1:0]        gnt_id;
  logic              busy;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      count;

  int checks = 0;
  int errors = 0;

  counter_share_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clock(clock), .resetN(resetN), .req(req), .dur(dur),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .done(done), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000 || count !== 16'd0 || gnt_id !== 2'd0) begin errors++; $display("FAIL reset_state: gnt=%b busy=%b done=%b count=%0d id=%0d required all zero", gnt, busy, done, count, gnt_id); end
    resetN = 1'b1;
    req = 4'b0001;
    dur[0*W +: W] = 16'd5;
    step();
    checks++; if (gnt !== 4'b0001 || count !== 16'd0 || busy !== 1'b1 || gnt_id !== 2'd0) begin errors++; $display("FAIL single_grant: gnt=%b count=%0d busy=%b id=%0d required 0001/0/1/0", gnt, count, busy, gnt_id); end
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (count !== 16'(k) || done !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL single_count: count=%0d done=%b busy=%b required %0d/0000/1", count, done, busy, k); end
    end
    step();
    checks++; if (done !== 4'b0001 || gnt !== 4'b0000 || busy !== 1'b0 || count !== 16'd5) begin errors++; $display("FAIL single_done: done=%b gnt=%b busy=%b count=%0d required 0001/0000/0/5", done, gnt, busy, count); end
    req = 4'b0000;
    step();
    checks++; if (done !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_done_width: done=%b busy=%b required 0000/0", done, busy); end
    step();
    checks++; if (gnt !== 4'b0000 || count !== 16'd5) begin errors++; $display("FAIL single_idle_hold: gnt=%b count=%0d required 0000/5", gnt, count); end
    $display("test_reset: single request dur=5 done");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    logic [3:0] exp_oh;
    resetN = 1'b0;
    #2;
    resetN = 1'b1;
    for (int i = 0; i < NREQ; i++) dur[i*W +: W] = 16'd2;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_id = 2'(i % 4);
      exp_oh = 4'b0001 << exp_id;
      step();
      checks++; if (gnt !== exp_oh || gnt_id !== exp_id) begin errors++; $display("FAIL rr_grant: gnt=%b id=%0d required %b/%0d", gnt, gnt_id, exp_oh, exp_id); end
      step();
      step();
      checks++; if (count !== 16'd2 || busy !== 1'b1) begin errors++; $display("FAIL rr_count: count=%0d busy=%b required 2/1", count, busy); end
      step();
      checks++; if (done !== exp_oh || busy !== 1'b0) begin errors++; $display("FAIL rr_done: done=%b busy=%b required %b/0", done, busy, exp_oh); end
      req[exp_id] = 1'b0;
      step();
      checks++; if (done !== 4'b0000 || gnt !== 4'b0000) begin errors++; $display("FAIL rr_gap: done=%b gnt=%b required 0000/0000", done, gnt); end
      req[exp_id] = 1'b1;
      $display("test_round_robin: grant %0d done", exp_id);
    end
    req = 4'b0000;
    step();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rr_quiet: gnt=%b busy=%b required 0000/0", gnt, busy); end
  endtask

  task automatic test_zero_dur();
    req = 4'b0100;
    dur[2*W +: W] = 16'd0;
    step();
    checks++; if (gnt !== 4'b0100 || gnt_id !== 2'd2 || count !== 16'd0) begin errors++; $display("FAIL zero_grant: gnt=%b id=%0d count=%0d required 0100/2/0", gnt, gnt_id, count); end
    step();
    checks++; if (done !== 4'b0100 || gnt !== 4'b0000 || count !== 16'd0) begin errors++; $display("FAIL zero_done: done=%b gnt=%b count=%0d required 0100/0000/0", done, gnt, count); end
    req = 4'b0000;
    step();
    checks++; if (done !== 4'b0000 || count !== 16'd0) begin errors++; $display("FAIL zero_after: done=%b count=%0d required 0000/0", done, count); end
    $display("test_zero_dur: requester 2 dur=0 done");
  endtask

  task automatic test_abort();
    req = 4'b0010;
    dur[1*W +: W] = 16'd10;
    dur[3*W +: W] = 16'd3;
    step();
    checks++; if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin errors++; $display("FAIL abort_grant: gnt=%b id=%0d required 0010/1", gnt, gnt_id); end
    for (int k = 0; k < 4; k++) step();
    checks++; if (count !== 16'd4) begin errors++; $display("FAIL abort_pre: count=%0d required 4", count); end
    req = 4'b1000;
    step();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000 || count !== 16'd4) begin errors++; $display("FAIL abort_exit: gnt=%b busy=%b done=%b count=%0d required 0000/0/0000/4", gnt, busy, done, count); end
    step();
    checks++; if (gnt !== 4'b1000 || gnt_id !== 2'd3 || count !== 16'd0 || done !== 4'b0000) begin errors++; $display("FAIL abort_next: gnt=%b id=%0d count=%0d done=%b required 1000/3/0/0000", gnt, gnt_id, count, done); end
    req = 4'b0000;
    step();
    checks++; if (gnt !== 4'b0000 || done !== 4'b0000) begin errors++; $display("FAIL abort_cleanup: gnt=%b done=%b required 0000/0000", gnt, done); end
    $display("test_abort: requester 1 aborted at count 4, requester 3 granted");
  endtask

  task automatic test_reset_mid();
    req = 4'b0001;
    dur[0*W +: W] = 16'd20;
    step();
    for (int k = 0; k < 7; k++) step();
    checks++; if (count !== 16'd7 || gnt !== 4'b0001) begin errors++; $display("FAIL rmid_pre: count=%0d gnt=%b required 7/0001", count, gnt); end
    #2;
    resetN = 1'b0;
    #1;
    checks++; if (count !== 16'd0 || gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin errors++; $display("FAIL rmid_async: count=%0d gnt=%b busy=%b done=%b required all zero", count, gnt, busy, done); end
    req = 4'b1001;
    #1;
    resetN = 1'b1;
    step();
    checks++; if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin errors++; $display("FAIL rmid_ptr: gnt=%b id=%0d required 0001/0", gnt, gnt_id); end
    req = 4'b0000;
    step();
    checks++; if (gnt !== 4'b0000 || done !== 4'b0000) begin errors++; $display("FAIL rmid_cleanup: gnt=%b done=%b required 0000/0000", gnt, done); end
    $display("test_reset_mid: async clear at count 7, requester 0 first after release");
  endtask

  task automatic test_max_dur();
    logic [W-1:0] prev;
    int n;
    int bad;
    req = 4'b0001;
    dur[0*W +: W] = 16'hFFFF;
    step();
    checks++; if (gnt !== 4'b0001 || count !== 16'd0) begin errors++; $display("FAIL max_grant: gnt=%b count=%0d required 0001/0", gnt, count); end
    prev = 16'd0;
    n = 0;
    bad = 0;
    while (count !== 16'hFFFF && n < 70000) begin
      step();
      n++;
      if (count !== prev + 16'd1 || busy !== 1'b1 || done !== 4'b0000) bad++;
      prev = count;
    end
    checks++; if (n !== 65535) begin errors++; $display("FAIL max_cycles: edges to FFFF=%0d required 65535", n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL max_monotonic: bad steps=%0d required 0", bad); end
    step();
    checks++; if (done !== 4'b0001 || count !== 16'hFFFF || busy !== 1'b0) begin errors++; $display("FAIL max_done: done=%b count=%0h busy=%b required 0001/ffff/0", done, count, busy); end
    req = 4'b0000;
    step();
    checks++; if (done !== 4'b0000 || count !== 16'hFFFF) begin errors++; $display("FAIL max_after: done=%b count=%0h required 0000/ffff", done, count); end
    $display("test_max_dur: dur=FFFF completed after %0d edges", n);
  endtask

  initial begin
    resetN = 1'b0;
    req    = '0;
    dur    = '0;
    test_reset();
    test_round_robin();
    test_zero_dur();
    test_abort();
    test_reset_mid();
    test_max_dur();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
